// File: rtl/lfsr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lfsr_pkg                                                        |
// | Purpose  : Shared types and constants for the LFSR decrypt engine:         |
// |            FSM state encoding, default tap table, default preamble         |
// |            character and the generic LFSR step function.                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package lfsr_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEED    = 3'd1,
    TRAIN   = 3'd2,
    DECRYPT = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int C_DEF_LW   = 6;
  localparam int C_DEF_NPAT = 6;

  // Candidate feedback tap masks, index 0 first.
  localparam logic [C_DEF_LW-1:0] C_DEFAULT_TAPS [C_DEF_NPAT] =
    '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

  localparam logic [7:0] C_PRE_CHAR = 8'h5F;

  // One Fibonacci step on the low w bits: shift left, feedback into bit 0.
  // Operates on a 32-bit container so one function serves any LFSR width;
  // callers truncate the result back to their own width.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s,
                                            input logic [31:0] taps,
                                            input int unsigned w);
    logic [31:0] mask;
    logic        fb;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    fb   = ^(s & taps & mask);
    return ((s << 1) | {31'd0, fb}) & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lfsr_n                                                          |
// | Purpose  : Parametrised LW-bit Fibonacci LFSR with load and step enable.   |
// | Ports    : clk, init (sync active-high reset, clears state)                |
// |            en    - advance one step                                        |
// |            load  - replace state with seed (wins over en)                  |
// |            seed  - load value                                              |
// |            taps  - feedback tap mask                                       |
// |            state - current register contents                               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module lfsr_n
  import lfsr_pkg::*;
#(
  parameter int LW = 6
) (
  input  logic          clk,
  input  logic          init,
  input  logic          en,
  input  logic          load,
  input  logic [LW-1:0] seed,
  input  logic [LW-1:0] taps,
  output logic [LW-1:0] state
);

  logic [LW-1:0] state_q;
  logic [LW-1:0] state_d;
  logic [LW-1:0] w_nxt;

  always_comb begin
    w_nxt   = LW'(lfsr_next(32'(state_q), 32'(taps), LW));
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (en) begin
      state_d = w_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/lfsr_decrypt_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lfsr_decrypt_engine                                             |
// | Purpose  : Reads an encrypted message from a synchronous-read memory,      |
// |            seeds NPAT candidate LFSRs from the first preamble symbol,      |
// |            picks the tap pattern that reproduces the known preamble and    |
// |            XOR-decrypts the payload back into memory.                      |
// | Ports    : clk, init (sync active-high reset), start (1-cycle request)     |
// |            mem_raddr / mem_rdata   - read port, data one cycle later       |
// |            mem_wr_en / mem_waddr / mem_wdata - registered write port       |
// |            done      - run complete, every write committed                 |
// |            no_match  - no candidate survived the preamble                  |
// |            pat_idx   - selected candidate (lowest surviving index)         |
// | Options  : STRIP_PAD_EN - suppress leading PRE_CHAR bytes of the payload   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module lfsr_decrypt_engine
  import lfsr_pkg::*;
#(
  parameter int             DW       = 8,
  parameter int             LW       = 6,
  parameter int             NPAT     = 6,
  parameter logic [LW-1:0]  TAPS [NPAT] = C_DEFAULT_TAPS,
  parameter int             PRE_LEN  = 7,
  parameter int             MSG_LEN  = 64,
  parameter logic [DW-1:0]  PRE_CHAR = DW'(C_PRE_CHAR),
  parameter int             RD_BASE  = 64,
  parameter int             WR_BASE  = 0,
  parameter int             AW       = 8
) (
  input  logic                    clk,
  input  logic                    init,
  input  logic                    start,
  output logic [AW-1:0]           mem_raddr,
  input  logic [DW-1:0]           mem_rdata,
  output logic                    mem_wr_en,
  output logic [AW-1:0]           mem_waddr,
  output logic [DW-1:0]           mem_wdata,
  output logic                    done,
  output logic                    no_match,
  output logic [$clog2(NPAT)-1:0] pat_idx
);

  localparam int              C_PW         = $clog2(NPAT);
  localparam int              C_KW         = $clog2(MSG_LEN) + 1;
  localparam logic [C_KW-1:0] C_K_LAST_PRE = C_KW'(PRE_LEN - 1);
  localparam logic [C_KW-1:0] C_K_LAST_MSG = C_KW'(MSG_LEN - 1);

  state_t             state_q,    state_d;
  logic [C_KW-1:0]    k_q,        k_d;
  logic [NPAT-1:0]    match_q,    match_d;
  logic [C_PW-1:0]    pat_idx_q,  pat_idx_d;
  logic               no_match_q, no_match_d;
  logic               done_q,     done_d;
  logic               wr_en_q,    wr_en_d;
  logic [AW-1:0]      waddr_q,    waddr_d;
  logic [DW-1:0]      wdata_q,    wdata_d;
  logic [AW-1:0]      wr_ptr_q,   wr_ptr_d;
`ifdef STRIP_PAD_EN
  logic               pad_seen_q, pad_seen_d;
`endif

  logic               w_lfsr_en;
  logic               w_lfsr_load;
  logic [LW-1:0]      w_key;
  logic [LW-1:0]      w_lfsr_state [NPAT];
  logic [LW-1:0]      w_lfsr_nxt   [NPAT];
  logic [DW-1:0]      w_dec;
  logic [AW-1:0]      w_raddr_run;

  // Recover the keystream value hidden under a preamble symbol.
  assign w_key = mem_rdata[LW-1:0] ^ PRE_CHAR[LW-1:0];

  // Look one symbol ahead so the next symbol is on mem_rdata next cycle.
  assign w_raddr_run = AW'(RD_BASE) + AW'(k_q) + AW'(1);

  generate
    for (genvar gi = 0; gi < NPAT; gi++) begin : g_lfsr
      lfsr_n #(
        .LW (LW)
      ) u_lfsr (
        .clk   (clk),
        .init  (init),
        .en    (w_lfsr_en),
        .load  (w_lfsr_load),
        .seed  (w_key),
        .taps  (TAPS[gi]),
        .state (w_lfsr_state[gi])
      );
      assign w_lfsr_nxt[gi] = LW'(lfsr_next(32'(w_lfsr_state[gi]), 32'(TAPS[gi]), LW));
    end
  endgenerate

  assign w_dec = mem_rdata ^ DW'(w_lfsr_nxt[pat_idx_q]);

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    match_d     = match_q;
    pat_idx_d   = pat_idx_q;
    no_match_d  = no_match_q;
    done_d      = done_q;
    wr_en_d     = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    wr_ptr_d    = wr_ptr_q;
    w_lfsr_en   = 1'b0;
    w_lfsr_load = 1'b0;
    mem_raddr   = AW'(RD_BASE);
`ifdef STRIP_PAD_EN
    pad_seen_d  = pad_seen_q;
`endif

    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (start) begin
          state_d = SEED;
          k_d     = '0;
        end
      end

      SEED: begin
        mem_raddr   = w_raddr_run;
        w_lfsr_load = 1'b1;
        match_d     = '1;
        wr_ptr_d    = AW'(WR_BASE);
        k_d         = C_KW'(1);
        state_d     = TRAIN;
`ifdef STRIP_PAD_EN
        pad_seen_d  = 1'b0;
`endif
      end

      TRAIN: begin
        mem_raddr = w_raddr_run;
        w_lfsr_en = 1'b1;
        k_d       = k_q + C_KW'(1);
        for (int i = 0; i < NPAT; i++) begin
          match_d[i] = match_q[i] & (w_lfsr_nxt[i] == w_key);
        end
        if (k_q == C_K_LAST_PRE) begin
          // Descending scan so the lowest surviving index is the one kept.
          pat_idx_d = '0;
          for (int i = NPAT - 1; i >= 0; i--) begin
            if (match_d[i]) begin
              pat_idx_d = C_PW'(i);
            end
          end
          no_match_d = ~|match_d;
          state_d    = DECRYPT;
        end
      end

      DECRYPT: begin
        mem_raddr = w_raddr_run;
        w_lfsr_en = 1'b1;
`ifdef STRIP_PAD_EN
        if (pad_seen_q || (w_dec != PRE_CHAR)) begin
          pad_seen_d = 1'b1;
          wr_en_d    = 1'b1;
          waddr_d    = wr_ptr_q;
          wdata_d    = w_dec;
          wr_ptr_d   = wr_ptr_q + AW'(1);
        end
`else
        wr_en_d  = 1'b1;
        waddr_d  = wr_ptr_q;
        wdata_d  = w_dec;
        wr_ptr_d = wr_ptr_q + AW'(1);
`endif
        if (k_q == C_K_LAST_MSG) begin
          state_d = DONE;
        end else begin
          k_d = k_q + C_KW'(1);
        end
      end

      DONE: begin
        // done rises one edge after entry, once the last registered write
        // has been committed to memory.
        done_d = 1'b1;
        if (start) begin
          state_d = SEED;
          k_d     = '0;
          done_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state_q    <= IDLE;
      k_q        <= '0;
      match_q    <= '1;
      pat_idx_q  <= '0;
      no_match_q <= 1'b0;
      done_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      waddr_q    <= AW'(WR_BASE);
      wdata_q    <= '0;
      wr_ptr_q   <= AW'(WR_BASE);
`ifdef STRIP_PAD_EN
      pad_seen_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      match_q    <= match_d;
      pat_idx_q  <= pat_idx_d;
      no_match_q <= no_match_d;
      done_q     <= done_d;
      wr_en_q    <= wr_en_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wr_ptr_q   <= wr_ptr_d;
`ifdef STRIP_PAD_EN
      pad_seen_q <= pad_seen_d;
`endif
    end
  end

  assign mem_wr_en = wr_en_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;
  assign done      = done_q;
  assign no_match  = no_match_q;
  assign pat_idx   = pat_idx_q;

endmodule
`default_nettype wire
